gray_counter_n: RTL and testbench
=================================

# gray_counter_n

Parametrised, loadable up/down counter with registered binary and Gray-code outputs. It generalises the fixed 3-bit Gray counter in width and adds direction control, enable, parallel load in binary or Gray form, a saturate/wrap mode and wrap/terminal flags. It sits wherever a cycle-aligned binary/Gray pair is needed: FIFO pointers, sequencers and Gray-pointer sources for clock-domain crossing.

## Interface
- WIDTH, 3, counter width in bits; legal range ≥ 2.
- RST_VAL, 0, binary reset value; must fit in WIDTH bits.
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- ld  in  1  parallel load strobe.
- ld_is_gray  in  1  1 = ld_val is Gray-coded, 0 = ld_val is binary.
- ld_val  in  WIDTH  load value.
- bin  out  WIDTH  registered binary count.
- gray  out  WIDTH  registered Gray code of bin, updated on the same edge as bin.
- wrap  out  1  one-cycle pulse when a count step wraps max↔0.
- at_max  out  1  high while bin == 2^WIDTH−1.
- at_min  out  1  high while bin == 0.

## Operation
- Priority per edge: rst > ld > en. Otherwise hold.
- Reset values:
  - bin = RST_VAL
  - gray = RST_VAL ^ (RST_VAL >> 1)
  - wrap = 0
  - at_max and at_min as decoded from RST_VAL.
- Load:
  - ld_is_gray = 0: next_bin = ld_val.
  - ld_is_gray = 1: next_bin = gray-to-binary of ld_val (bit i = XOR of ld_val[WIDTH-1:i]).
  - A load never asserts wrap.
- Count (en = 1, ld = 0):
  - up = 1: next_bin = bin + 1, modulo 2^WIDTH.
  - up = 0: next_bin = bin − 1, modulo 2^WIDTH.
- SATURATE = 1: an increment at max holds max, and a decrement at 0 holds 0. wrap never asserts.
- SATURATE = 0: wrap is registered high for exactly one cycle after an edge where the count went max→0 (up) or 0→max (down). It is low on all other cycles.
- gray is computed from next_bin as next_bin ^ (next_bin >> 1) and registered. It is never derived combinationally from bin, so it is glitch-free and cycle-aligned with bin.
- Between consecutive count steps, gray changes in exactly one bit, including the wrap step. Load, reset and saturation holds are exempt.
- at_max and at_min are decoded from registered bin only. They are glitch-free because they have no input-to-output combinational path.
- en and up are ignored on a cycle where ld = 1. ld_val and ld_is_gray are ignored when ld = 0.
- Changing up between cycles takes effect on the next enabled edge. There is no pipeline to drain.

## Timing
- Latency: 1 clock from any sampled input (rst, ld, en, up) to bin, gray, wrap, at_max and at_min.
- All outputs are direct register outputs or pure decodes of registers. There is no combinational path from any input to any output.
- Reset mid-count: the next edge forces the reset values regardless of en, ld and up. Counting resumes on the first edge after rst deasserts.
- Simultaneous ld and en: the load wins, the count is not applied, and wrap = 0.
- Simultaneous rst and ld: reset wins.
- A wrap pulse may repeat every 2^WIDTH enabled cycles. With WIDTH = 2 and continuous up-counting, it repeats every 4 cycles.

## Test plan
- Reset / up count (WIDTH = 3, SATURATE = 0): hold rst for 2 cycles, then en = 1, up = 1 for 9 cycles.
  - After reset: bin = 0, gray = 000, at_min = 1.
  - gray sequence: 001, 011, 010, 110, 111, 101, 100, 000.
  - wrap high only in the cycle bin returns to 0.
  - Exactly one gray bit changes per step.
- Down count with wrap: from bin = 0, apply en = 1, up = 0.
  - bin → 7, gray = 100, wrap = 1, at_max = 1.
  - Next step: bin = 6, gray = 101, wrap = 0.
- Saturate (SATURATE = 1): load 7, then 3 cycles of up.
  - bin stays 7, gray stays 100, wrap stays 0.
  - Then 8 down-steps from 7: bin ends at 0 and holds 0 on the 8th.
- Gray and binary load:
  - ld = 1, ld_is_gray = 1, ld_val = 110 → bin = 100, gray = 110.
  - ld = 1, ld_is_gray = 0, ld_val = 101 → bin = 101, gray = 111.
- Priority: at bin = 7 with en = 1, up = 1, apply ld = 1, ld_val = 2 (binary).
  - Result: bin = 2, wrap = 0.
  - Next cycle, assert rst together with ld: bin = RST_VAL.
- Randomised width sweep (WIDTH = 2, 5, 8), random en, up and ld for 10k cycles.
  - The scoreboard model matches bin, gray, wrap, at_max and at_min every cycle.
  - Every count step shows a single-bit Gray change.

Source files
------------

// File: rtl/gray_counter_n.sv
// Loadable up/down counter with registered binary and Gray outputs.
// Gray is registered from the next binary value, so both outputs change on the same edge.
module gray_counter_n #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic             ld_is_gray,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_ld_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic             w_next_wrap;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_ld_bin = gray_to_bin(ld_val);

    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (ld) begin
            w_next_bin = ld_is_gray ? w_ld_bin : ld_val;
        end else if (en) begin
            if (up) begin
                if (r_bin != MAX_VAL) begin
                    w_next_bin = r_bin + ONE;
                end else if (!SATURATE) begin
                    w_next_bin  = '0;
                    w_next_wrap = 1'b1;
                end
            end else begin
                if (r_bin != '0) begin
                    w_next_bin = r_bin - ONE;
                end else if (!SATURATE) begin
                    w_next_bin  = MAX_VAL;
                    w_next_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= RST_VAL;
            r_gray <= RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
            r_wrap <= w_next_wrap;
        end
    end

    assign bin    = r_bin;
    assign gray   = r_gray;
    assign wrap   = r_wrap;
    assign at_max = (r_bin == MAX_VAL);
    assign at_min = (r_bin == '0);

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: five instances (widths 3,3,2,5,8, wrap and saturate),
// directed scripts on the two 3-bit instances followed by random stimulus on all.
module tb_gray_counter_n;

    localparam int NI    = 5;
    localparam int NRAND = 10000;
    localparam int WID  [NI] = '{3, 3, 2, 5, 8};
    localparam int SATV [NI] = '{0, 1, 0, 1, 0};
    localparam int RSTV [NI] = '{0, 0, 2, 19, 200};

    typedef struct {
        bit r, e, u, l, lg;
        int lv;
        bit dchk;
        int dbin, dgray;
        bit dwrap;
    } stim_t;

    typedef struct {
        int bin, gray;
        bit wrap, amax, amin, step, dchk;
        int dbin, dgray;
        bit dwrap;
    } exp_t;

    logic clk;
    logic rst_a [NI];
    logic en_a  [NI];
    logic up_a  [NI];
    logic ld_a  [NI];
    logic lg_a  [NI];
    logic [2:0] lv0;
    logic [2:0] lv1;
    logic [1:0] lv2;
    logic [4:0] lv3;
    logic [7:0] lv4;
    logic [2:0] bin0, gray0;
    logic [2:0] bin1, gray1;
    logic [1:0] bin2, gray2;
    logic [4:0] bin3, gray3;
    logic [7:0] bin4, gray4;
    logic wrap_o [NI];
    logic amax_o [NI];
    logic amin_o [NI];

    stim_t scr [2][$];
    exp_t  sb [NI][$];
    int    m_bin [NI];
    int    n_pass;
    int    n_total;
    bit    fin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3), .RST_VAL(3'd0), .SATURATE(1'b0)) u_d0 (
        .clk(clk), .rst(rst_a[0]), .en(en_a[0]), .up(up_a[0]), .ld(ld_a[0]),
        .ld_is_gray(lg_a[0]), .ld_val(lv0), .bin(bin0), .gray(gray0),
        .wrap(wrap_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));
    gray_counter_n #(.WIDTH(3), .RST_VAL(3'd0), .SATURATE(1'b1)) u_d1 (
        .clk(clk), .rst(rst_a[1]), .en(en_a[1]), .up(up_a[1]), .ld(ld_a[1]),
        .ld_is_gray(lg_a[1]), .ld_val(lv1), .bin(bin1), .gray(gray1),
        .wrap(wrap_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));
    gray_counter_n #(.WIDTH(2), .RST_VAL(2'd2), .SATURATE(1'b0)) u_d2 (
        .clk(clk), .rst(rst_a[2]), .en(en_a[2]), .up(up_a[2]), .ld(ld_a[2]),
        .ld_is_gray(lg_a[2]), .ld_val(lv2), .bin(bin2), .gray(gray2),
        .wrap(wrap_o[2]), .at_max(amax_o[2]), .at_min(amin_o[2]));
    gray_counter_n #(.WIDTH(5), .RST_VAL(5'd19), .SATURATE(1'b1)) u_d3 (
        .clk(clk), .rst(rst_a[3]), .en(en_a[3]), .up(up_a[3]), .ld(ld_a[3]),
        .ld_is_gray(lg_a[3]), .ld_val(lv3), .bin(bin3), .gray(gray3),
        .wrap(wrap_o[3]), .at_max(amax_o[3]), .at_min(amin_o[3]));
    gray_counter_n #(.WIDTH(8), .RST_VAL(8'd200), .SATURATE(1'b0)) u_d4 (
        .clk(clk), .rst(rst_a[4]), .en(en_a[4]), .up(up_a[4]), .ld(ld_a[4]),
        .ld_is_gray(lg_a[4]), .ld_val(lv4), .bin(bin4), .gray(gray4),
        .wrap(wrap_o[4]), .at_max(amax_o[4]), .at_min(amin_o[4]));

    // Inverse Gray lookup: the binary value whose Gray code equals g.
    function automatic int g2b(input int g, input int w);
        for (int b = 0; b < (1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    task automatic add(input int k, input bit r, input bit e, input bit u, input bit l,
                       input bit lg, input int lv, input bit dc, input int db,
                       input int dg, input bit dw);
        stim_t s;
        s.r = r; s.e = e; s.u = u; s.l = l; s.lg = lg; s.lv = lv;
        s.dchk = dc; s.dbin = db; s.dgray = dg; s.dwrap = dw;
        scr[k].push_back(s);
    endtask

    // Reference model: next value from arithmetic on the count, then push the expectation.
    task automatic apply(input int k, input stim_t s);
        int   mx;
        int   nb;
        int   raw;
        exp_t x;
        mx     = (1 << WID[k]) - 1;
        nb     = m_bin[k];
        x.wrap = 1'b0;
        x.step = 1'b0;
        if (s.r) begin
            nb = RSTV[k];
        end else if (s.l) begin
            nb = s.lg ? g2b(s.lv, WID[k]) : s.lv;
        end else if (s.e) begin
            raw = m_bin[k] + (s.u ? 1 : -1);
            if (raw < 0 || raw > mx) begin
                if (SATV[k] != 0) begin
                    raw = m_bin[k];
                end else begin
                    raw    = (raw + mx + 1) % (mx + 1);
                    x.wrap = 1'b1;
                end
            end
            x.step = (raw != m_bin[k]);
            nb     = raw;
        end
        m_bin[k] = nb;
        x.bin    = nb;
        x.gray   = nb ^ (nb >> 1);
        x.amax   = (nb == mx);
        x.amin   = (nb == 0);
        x.dchk   = s.dchk;
        x.dbin   = s.dbin;
        x.dgray  = s.dgray;
        x.dwrap  = s.dwrap;
        sb[k].push_back(x);

        rst_a[k] = s.r;
        en_a[k]  = s.e;
        up_a[k]  = s.u;
        ld_a[k]  = s.l;
        lg_a[k]  = s.lg;
        case (k)
            0: lv0 = s.lv[2:0];
            1: lv1 = s.lv[2:0];
            2: lv2 = s.lv[1:0];
            3: lv3 = s.lv[4:0];
            default: lv4 = s.lv[7:0];
        endcase
    endtask

    function automatic stim_t rand_stim(input int k, input int bias);
        stim_t s;
        s.r    = ($urandom_range(63) == 0);
        s.l    = ($urandom_range(7) == 0);
        s.lg   = $urandom_range(1) == 1;
        s.lv   = int'($urandom_range((1 << WID[k]) - 1));
        s.e    = ($urandom_range(3) != 0);
        s.u    = ($urandom_range(99) < bias);
        s.dchk = 1'b0;
        s.dbin = 0;
        s.dgray = 0;
        s.dwrap = 1'b0;
        return s;
    endfunction

    // Stimulus driver: inputs change on the falling edge, expectations queued at the same time.
    initial begin
        int    bias;
        stim_t s;
        int    ub [9];
        int    ug [9];
        int    db [8];
        int    dg [8];
        fin = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rst_a[k] = 1'b1; en_a[k] = 1'b0; up_a[k] = 1'b0; ld_a[k] = 1'b0; lg_a[k] = 1'b0;
            m_bin[k] = RSTV[k];
        end
        lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0; lv4 = '0;

        // 3-bit wrapping instance
        ub = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        ug = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 1, 1, 0, 0, 0, 1, ub[i], ug[i], i == 7);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 7, 4, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 6, 5, 0);
        add(0, 0, 0, 0, 1, 1, 6, 1, 4, 6, 0);
        add(0, 0, 0, 0, 1, 0, 5, 1, 5, 7, 0);
        add(0, 0, 0, 0, 1, 0, 7, 1, 7, 4, 0);
        add(0, 0, 1, 1, 1, 0, 2, 1, 2, 3, 0);
        add(0, 1, 1, 1, 1, 0, 5, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);

        // 3-bit saturating instance
        db = '{6, 5, 4, 3, 2, 1, 0, 0};
        dg = '{5, 7, 6, 2, 3, 1, 0, 0};
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 7, 1, 7, 4, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 0, 0, 1, 7, 4, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 0, 0, 0, 1, db[i], dg[i], 0);

        bias = 50;
        for (int c = 0; c < NRAND; c++) begin
            @(negedge clk);
            if (c % 200 == 0) begin
                case ($urandom_range(2))
                    0: bias = 10;
                    1: bias = 50;
                    default: bias = 90;
                endcase
            end
            for (int k = 0; k < NI; k++) begin
                if (k < 2 && scr[k].size() > 0) s = scr[k].pop_front();
                else                            s = rand_stim(k, bias);
                apply(k, s);
            end
        end
        @(negedge clk);
        fin = 1'b1;
    end

    // Monitor: one queued expectation per instance per rising edge.
    always @(posedge clk) begin
        int   ab [NI];
        int   ag [NI];
        int   pg [NI];
        exp_t x;
        #1;
        ab[0] = int'(bin0); ag[0] = int'(gray0);
        ab[1] = int'(bin1); ag[1] = int'(gray1);
        ab[2] = int'(bin2); ag[2] = int'(gray2);
        ab[3] = int'(bin3); ag[3] = int'(gray3);
        ab[4] = int'(bin4); ag[4] = int'(gray4);
        for (int k = 0; k < NI; k++) begin
            if (sb[k].size() > 0) begin
                x = sb[k].pop_front();
                n_total++;
                if (ab[k] == x.bin && ag[k] == x.gray && wrap_o[k] == x.wrap &&
                    amax_o[k] == x.amax && amin_o[k] == x.amin) begin
                    n_pass++;
                end else begin
                    $display("FAIL u%0d model t=%0t: got bin=%0d gray=%0d wrap=%0b at_max=%0b at_min=%0b, expected bin=%0d gray=%0d wrap=%0b at_max=%0b at_min=%0b",
                             k, $time, ab[k], ag[k], wrap_o[k], amax_o[k], amin_o[k],
                             x.bin, x.gray, x.wrap, x.amax, x.amin);
                end
                if (x.step) begin
                    n_total++;
                    if ($countones(ag[k] ^ pg[k]) == 1) n_pass++;
                    else $display("FAIL u%0d gray_step t=%0t: gray %0d -> %0d, expected one bit change",
                                  k, $time, pg[k], ag[k]);
                end
                if (x.dchk) begin
                    n_total++;
                    if (ab[k] == x.dbin && ag[k] == x.dgray && wrap_o[k] == x.dwrap) n_pass++;
                    else $display("FAIL u%0d directed t=%0t: got bin=%0d gray=%0d wrap=%0b, expected bin=%0d gray=%0d wrap=%0b",
                                  k, $time, ab[k], ag[k], wrap_o[k], x.dbin, x.dgray, x.dwrap);
                end
            end
            pg[k] = ag[k];
        end
        if (fin) begin
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

endmodule
